bus_trace_uart: RTL

Passive bus-trace stage downstream of the 8088 system top. It consumes the decoded bus strobes, CPU address, and bus data that the system top exports for debug. Each completed read/write cycle becomes a 4-byte record, buffered in a small FIFO and streamed out an independent 8N1 UART pin, so the host sees live bus activity without disturbing the CPU UART.

---
 rtl/bus_trace_uart.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_trace_uart.sv
// Passive bus tracer: each completed 8088 bus cycle becomes a 4-byte record, queued and sent out an 8N1 UART.
// Optional build macro TRACE_MEM_READ_EN enables capture of memory-read (mrdc_n) cycles.
module bus_trace_uart #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cap_en,
   input  logic [19:0] cpu_addr,
   input  logic [7:0]  bus_data,
   input  logic        mrdc_n,
   input  logic        mwtc_n,
   input  logic        iorc_n,
   input  logic        iowc_n,
   output logic        trace_tx,
   output logic        overflow,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLK_DIV - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   // Strobe vector is indexed by record type code.
   logic [3:0]  s_in, s_q, fall;
   logic        pend_q, pend_d;
   logic [1:0]  ptype_q, ptype_d;
   logic [19:0] paddr_q, paddr_d;
   logic        push, rise_pend;
   logic [29:0] rec_in;

   assign s_in = {iowc_n, iorc_n, mwtc_n, mrdc_n};
`ifdef TRACE_MEM_READ_EN
   assign fall = s_q & ~s_in;
`else
   assign fall = s_q & ~s_in & 4'b1110;
`endif
   assign rec_in    = {ptype_q, paddr_q, bus_data};
   assign rise_pend = pend_q & ~s_q[ptype_q] & s_in[ptype_q];

   always_comb begin
      pend_d  = pend_q;
      ptype_d = ptype_q;
      paddr_d = paddr_q;
      push    = 1'b0;
      if (rise_pend) begin
         pend_d = 1'b0;
         push   = cap_en;
      end else if (!pend_q && (|fall)) begin
         pend_d  = 1'b1;
         paddr_d = cpu_addr;
         if (fall[1])      ptype_d = 2'b01;
         else if (fall[0]) ptype_d = 2'b00;
         else if (fall[3]) ptype_d = 2'b11;
         else              ptype_d = 2'b10;
      end
   end

   logic [29:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic        empty, full, pop, wr_en, drop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;
   assign wr_d  = wr_q + {{AW{1'b0}}, wr_en};
   assign rd_d  = rd_q + {{AW{1'b0}}, pop};

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= rec_in;
   end

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    idx_q, idx_d;
   logic [29:0]   rec_q, rec_d;
   logic [7:0]    sh_q, sh_d;
   logic          tx_q, tx_d, busy_q, busy_d, ovf_q;

   assign pop = (state_q == S_IDLE) && !empty;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      rec_d   = rec_q;
      sh_d    = sh_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               rec_d   = mem_q[rd_q[AW-1:0]];
               idx_d   = 2'd0;
               cnt_d   = BAUD_RELOAD;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            case (idx_q)
               2'd0:    sh_d = {rec_q[29:28], 2'b00, rec_q[27:24]};
               2'd1:    sh_d = rec_q[23:16];
               2'd2:    sh_d = rec_q[15:8];
               default: sh_d = rec_q[7:0];
            endcase
            cnt_d   = BAUD_RELOAD;
            state_d = S_START;
         end
         S_START: begin
            if (cnt_q == '0) begin
               cnt_d   = BAUD_RELOAD;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = BAUD_RELOAD;
               sh_d  = {1'b0, sh_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_STOP: begin
            // Between bytes the stop bit ends one cycle early so LOAD fills it: no gap in the record.
            if (idx_q != 2'd3 && cnt_q == CW'(1)) begin
               idx_d   = idx_q + 2'd1;
               cnt_d   = BAUD_RELOAD;
               state_d = S_LOAD;
            end else if (cnt_q == '0) begin
               cnt_d   = BAUD_RELOAD;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      if (state_q == S_START)     tx_d = 1'b0;
      else if (state_q == S_DATA) tx_d = sh_q[0];
   end

   assign busy_d = (wr_d != rd_d) || (state_d != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= '1;
         pend_q  <= 1'b0;
         ptype_q <= '0;
         paddr_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         rec_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         s_q     <= s_in;
         pend_q  <= pend_d;
         ptype_q <= ptype_d;
         paddr_q <= paddr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         rec_q   <= rec_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_q | drop;
      end
   end

   assign trace_tx = tx_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;

endmodule
